// File: rtl/alu_regfile.sv
// Register file and writeback stage for the 8-bit ALU, with flags and a sequenced clear.
// Optional macro ALU_RF_BYPASS_EN forwards an accepted writeback to matching read ports.
//
// state   | meaning
// S_IDLE  | normal operation; writebacks accepted
// S_CLEAR | zeroing registers 1..NREGS-1, one per cycle
module alu_regfile #(
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [7:0]        rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [7:0]        rd_data_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [7:0]        wb_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              flag_z,
  output logic              flag_n
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]        r_regs [NREGS];
  logic              r_flag_z, r_flag_n, r_clr_done;
  logic              w_xfer, w_last;
  logic [7:0]        w_stored_a, w_stored_b;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last      = 1'b0;
    busy        = 1'b0;
    wb_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        wb_ready = !clr_req && rst_n;
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = ADDR_W'(1);
        end
      end
      S_CLEAR: begin
        busy      = 1'b1;
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == LAST_ADDR) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_xfer = wb_valid && wb_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_flag_z   <= 1'b1;
      r_flag_n   <= 1'b0;
      r_clr_done <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_clr_done <= w_last;
      if (r_state == S_CLEAR) r_regs[r_cnt] <= 8'h00;
      // Register 0 is never written, so it stays at its reset value of zero.
      if (w_xfer && (wb_addr != '0)) r_regs[wb_addr] <= wb_data;
      if (w_xfer) begin
        r_flag_z <= (wb_data == 8'h00);
        r_flag_n <= wb_data[7];
      end else if (w_last) begin
        r_flag_z <= 1'b1;
        r_flag_n <= 1'b0;
      end
    end
  end

  assign w_stored_a = (rd_addr_a == '0) ? 8'h00 : r_regs[rd_addr_a];
  assign w_stored_b = (rd_addr_b == '0) ? 8'h00 : r_regs[rd_addr_b];

`ifdef ALU_RF_BYPASS_EN
  // A transfer implies S_IDLE, so nothing is forwarded during a clear.
  assign rd_data_a = (w_xfer && (wb_addr != '0) && (rd_addr_a == wb_addr)) ? wb_data : w_stored_a;
  assign rd_data_b = (w_xfer && (wb_addr != '0) && (rd_addr_b == wb_addr)) ? wb_data : w_stored_b;
`else
  assign rd_data_a = w_stored_a;
  assign rd_data_b = w_stored_b;
`endif

  assign clr_done = r_clr_done;
  assign flag_z   = r_flag_z;
  assign flag_n   = r_flag_n;

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: directed scenarios plus randomized writebacks
// compared against an array-based reference model.
module tb_alu_regfile;
  localparam int NREGS = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wb_addr;
  logic [7:0]    rd_data_a, rd_data_b, wb_data;
  logic          wb_valid, wb_ready, clr_req, busy, clr_done, flag_z, flag_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_regs [NREGS];
  logic       m_z, m_n;

  always #5 clk = ~clk;

  alu_regfile #(.NREGS(NREGS), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .flag_z(flag_z), .flag_n(flag_n)
  );

  function automatic logic [7:0] m_rd(input logic [AW-1:0] a);
    return (a == '0) ? 8'h00 : m_regs[a];
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [7:0] d);
    if (a != '0) m_regs[a] = d;
    m_z = (d == 8'h00);
    m_n = d[7];
  endtask

  task automatic model_zero();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_z = 1'b1;
    m_n = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    step();
    wb_valid = 1'b0;
    model_write(a, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_req = 1'b0;
    wb_valid = 1'b1; wb_addr = 2'd1; wb_data = 8'hEE;
    step();
    @(negedge clk);
    n_checks++;
    if (wb_ready !== 1'b0) begin n_errors++; $display("FAIL ready_in_reset got %b exp 0", wb_ready); end
    step();
    wb_valid = 1'b0;
    rst_n = 1'b1;
    model_zero();
    @(negedge clk);
    n_checks++;
    if ({flag_z, flag_n, busy, clr_done, wb_ready} !== 5'b10001) begin
      n_errors++; $display("FAIL reset_outputs got z%b n%b busy%b done%b rdy%b exp 1 0 0 0 1",
                           flag_z, flag_n, busy, clr_done, wb_ready);
    end
    for (int i = 0; i < NREGS; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(i);
      #1;
      n_checks++;
      if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
        n_errors++; $display("FAIL reset_read r%0d got a=%h b=%h exp 00", i, rd_data_a, rd_data_b);
      end
    end
  endtask

  task automatic test_write_flags();
    do_write(2'd2, 8'hA5);
    rd_addr_a = 2'd2;
    @(negedge clk);
    n_checks++;
    if (rd_data_a !== m_rd(2'd2)) begin n_errors++; $display("FAIL wr_a5 got %h exp %h", rd_data_a, m_rd(2'd2)); end
    n_checks++;
    if ({flag_z, flag_n} !== {m_z, m_n}) begin n_errors++; $display("FAIL flags_a5 got %b%b exp %b%b", flag_z, flag_n, m_z, m_n); end
    do_write(2'd3, 8'h00);
    rd_addr_b = 2'd3;
    @(negedge clk);
    n_checks++;
    if (rd_data_b !== m_rd(2'd3)) begin n_errors++; $display("FAIL wr_00 got %h exp %h", rd_data_b, m_rd(2'd3)); end
    n_checks++;
    if ({flag_z, flag_n} !== {m_z, m_n}) begin n_errors++; $display("FAIL flags_00 got %b%b exp %b%b", flag_z, flag_n, m_z, m_n); end
  endtask

  task automatic test_r0();
    do_write(2'd0, 8'h7F);
    rd_addr_a = 2'd0;
    @(negedge clk);
    n_checks++;
    if (rd_data_a !== 8'h00) begin n_errors++; $display("FAIL r0_read got %h exp 00", rd_data_a); end
    n_checks++;
    if ({flag_z, flag_n} !== {m_z, m_n}) begin n_errors++; $display("FAIL r0_flags got %b%b exp %b%b", flag_z, flag_n, m_z, m_n); end
  endtask

  task automatic test_clear();
    int busy_cnt, done_cnt;
    do_write(2'd1, 8'h11);
    do_write(2'd2, 8'h22);
    do_write(2'd3, 8'h33);
    rd_addr_a = 2'd3; rd_addr_b = 2'd1;
    clr_req = 1'b1; wb_valid = 1'b1; wb_addr = 2'd1; wb_data = 8'h55;
    @(negedge clk);
    n_checks++;
    if (wb_ready !== 1'b0) begin n_errors++; $display("FAIL clr_blocks_wb got %b exp 0", wb_ready); end
    step();
    clr_req = 1'b0; wb_valid = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        n_checks++;
        if (rd_data_b !== ((busy_cnt == 0) ? 8'h11 : 8'h00)) begin
          n_errors++; $display("FAIL clr_r1 cycle %0d got %h", busy_cnt, rd_data_b);
        end
        n_checks++;
        if (rd_data_a !== 8'h33) begin n_errors++; $display("FAIL clr_r3_pending cycle %0d got %h exp 33", busy_cnt, rd_data_a); end
        busy_cnt++;
      end
      if (clr_done === 1'b1) done_cnt++;
      clr_req = (c == 1);
      step();
      clr_req = 1'b0;
    end
    n_checks++;
    if (busy_cnt != NREGS - 1) begin n_errors++; $display("FAIL clr_busy_len got %0d exp %0d", busy_cnt, NREGS - 1); end
    n_checks++;
    if (done_cnt != 1) begin n_errors++; $display("FAIL clr_done_pulses got %0d exp 1", done_cnt); end
    model_zero();
    @(negedge clk);
    n_checks++;
    if ({flag_z, flag_n} !== {m_z, m_n}) begin n_errors++; $display("FAIL clr_flags got %b%b exp %b%b", flag_z, flag_n, m_z, m_n); end
    for (int i = 0; i < NREGS; i++) begin
      rd_addr_a = AW'(i);
      #1;
      n_checks++;
      if (rd_data_a !== m_rd(AW'(i))) begin n_errors++; $display("FAIL clr_final r%0d got %h exp 00", i, rd_data_a); end
    end
  endtask

  task automatic test_back_to_back_clear();
    bit seen;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (clr_done === 1'b1) seen = 1;
      else step();
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL b2b_first_done got timeout exp pulse"); end
    clr_req = 1'b1;
    #1;
    n_checks++;
    if (wb_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_ready got %b exp 0", wb_ready); end
    step();
    clr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || clr_done !== 1'b0) begin
      n_errors++; $display("FAIL b2b_restart got busy%b done%b exp 1 0", busy, clr_done);
    end
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      @(negedge clk);
      if (clr_done === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL b2b_second_done got timeout exp pulse"); end
    step();
    model_zero();
  endtask

  task automatic test_reset_mid_clear();
    do_write(2'd1, 8'hAA);
    do_write(2'd2, 8'hBB);
    do_write(2'd3, 8'hCC);
    rd_addr_a = 2'd1; rd_addr_b = 2'd3;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || rd_data_a !== 8'h00 || rd_data_b !== 8'hCC) begin
      n_errors++; $display("FAIL midclr_state got busy%b r1=%h r3=%h exp 1 00 cc", busy, rd_data_a, rd_data_b);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_zero();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || wb_ready !== 1'b1) begin
      n_errors++; $display("FAIL midrst_ctrl got busy%b done%b rdy%b exp 0 0 1", busy, clr_done, wb_ready);
    end
    for (int i = 1; i < NREGS; i++) begin
      rd_addr_a = AW'(i);
      #1;
      n_checks++;
      if (rd_data_a !== m_rd(AW'(i))) begin n_errors++; $display("FAIL midrst_r%0d got %h exp 00", i, rd_data_a); end
    end
    step();
    @(negedge clk);
    n_checks++;
    if (clr_done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL midrst_no_done got done%b busy%b exp 0 0", clr_done, busy); end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_v;
    do_write(2'd2, 8'h99);
    rd_addr_a = 2'd2; rd_addr_b = 2'd2;
    wb_valid = 1'b1; wb_addr = 2'd2; wb_data = 8'h3C;
`ifdef ALU_RF_BYPASS_EN
    exp_v = 8'h3C;
`else
    exp_v = m_rd(2'd2);
`endif
    @(negedge clk);
    n_checks++;
    if (rd_data_a !== exp_v || rd_data_b !== exp_v) begin
      n_errors++; $display("FAIL bypass_same_cycle got a=%h b=%h exp %h", rd_data_a, rd_data_b, exp_v);
    end
    step();
    wb_valid = 1'b0;
    model_write(2'd2, 8'h3C);
    @(negedge clk);
    n_checks++;
    if (rd_data_a !== m_rd(2'd2) || rd_data_b !== m_rd(2'd2)) begin
      n_errors++; $display("FAIL bypass_next_cycle got a=%h b=%h exp %h", rd_data_a, rd_data_b, m_rd(2'd2));
    end
    rd_addr_a = 2'd0;
    wb_valid = 1'b1; wb_addr = 2'd0; wb_data = 8'h5A;
    @(negedge clk);
    n_checks++;
    if (rd_data_a !== 8'h00) begin n_errors++; $display("FAIL bypass_r0 got %h exp 00", rd_data_a); end
    step();
    wb_valid = 1'b0;
    model_write(2'd0, 8'h5A);
  endtask

  task automatic test_random();
    logic [7:0] exp_a, exp_b;
    for (int it = 0; it < 300; it++) begin
      wb_valid  = 1'($urandom_range(0, 1));
      wb_addr   = AW'($urandom_range(0, NREGS - 1));
      wb_data   = 8'($urandom);
      rd_addr_a = AW'($urandom_range(0, NREGS - 1));
      rd_addr_b = AW'($urandom_range(0, NREGS - 1));
      exp_a = m_rd(rd_addr_a);
      exp_b = m_rd(rd_addr_b);
`ifdef ALU_RF_BYPASS_EN
      if (wb_valid && wb_addr != '0 && rd_addr_a == wb_addr) exp_a = wb_data;
      if (wb_valid && wb_addr != '0 && rd_addr_b == wb_addr) exp_b = wb_data;
`endif
      @(negedge clk);
      n_checks++;
      if (wb_ready !== 1'b1) begin n_errors++; $display("FAIL rnd_ready it %0d got %b exp 1", it, wb_ready); end
      n_checks++;
      if (rd_data_a !== exp_a || rd_data_b !== exp_b) begin
        n_errors++; $display("FAIL rnd_read it %0d got a=%h b=%h exp a=%h b=%h", it, rd_data_a, rd_data_b, exp_a, exp_b);
      end
      n_checks++;
      if ({flag_z, flag_n} !== {m_z, m_n}) begin
        n_errors++; $display("FAIL rnd_flags it %0d got %b%b exp %b%b", it, flag_z, flag_n, m_z, m_n);
      end
      step();
      if (wb_valid) model_write(wb_addr, wb_data);
    end
    wb_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = 8'h00;
    clr_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    model_zero();
    step();
    test_reset();
    test_write_flags();
    test_r0();
    test_clear();
    test_back_to_back_clear();
    test_reset_mid_clear();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
